// File: rtl/prod_accum.sv
// Accumulates a stream of unsigned products into a wide running sum.
// The sum, term count and sticky overflow are presented on a valid/ready output when a `last` beat arrives.
module prod_accum #(
   parameter int unsigned PROD_W = 16,
   parameter int unsigned ACC_W  = 24,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_overflow
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               oflag_q, oflag_d;
   logic [ACC_W:0]     sum_ext;
   logic               accept;

   assign in_ready     = (state_q != DONE);
   assign out_valid    = (state_q == DONE);
   assign accept       = in_valid && in_ready;
   assign out_sum      = sum_q;
   assign out_count    = count_q;
   assign out_overflow = oflag_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      count_d = count_q;
      oflag_d = oflag_q;
      sum_ext = {1'b0, acc_q} + {1'b0, ACC_W'(in_prod)};

      case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d = ACC_W'(in_prod);
               cnt_d = CNT_W'(1);
               ovf_d = 1'b0;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d = sum_ext[ACC_W-1:0];
               ovf_d = ovf_q | sum_ext[ACC_W];
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The result registers capture the next-state values so the last beat is included.
      if (accept) begin
         state_d = in_last ? DONE : ACCUM;
         if (in_last) begin
            sum_d   = acc_d;
            count_d = cnt_d;
            oflag_d = ovf_d;
         end
      end

      if (clr) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         sum_d   = '0;
         count_d = '0;
         oflag_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         oflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         oflag_q <= oflag_d;
      end
   end

endmodule

// File: doc/prod_accum.md
Name: prod_accum

Overview:
- Downstream consumer of the 8x8 combinational multiplier's 16-bit product `res`.
- Accepts a stream of products over a valid/ready handshake and accumulates them into a wide running sum.
- Presents the completed sum, term count and overflow flag on a second valid/ready handshake when a beat tagged `last` arrives.
- Sits between the multiplier output and the display/readout logic.

Parameters:
- PROD_W, 16, width of incoming product (matches multiplier result width).
- ACC_W, 24, accumulator width; must be >= PROD_W.
- CNT_W, 8, width of the term counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous abort; discards the partial sum and returns to IDLE.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_prod  input  PROD_W  product value (unsigned).
- in_last  input  1  marks the final beat of the current group.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_W  accumulated sum (unsigned, modulo 2^ACC_W).
- out_count  output  CNT_W  number of beats in the group (saturating).
- out_overflow  output  1  sticky: the sum carried out of ACC_W during the group.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; accumulator, count, overflow = 0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready=1 on the cycle after reset is released.
- States: IDLE, ACCUM, DONE.
- in_ready=1 in IDLE and ACCUM; in_ready=0 in DONE. in_ready is a pure decode of state, with no combinational path from out_ready.
- A beat is accepted when in_valid && in_ready at a rising edge.
- IDLE, on accept:
  - acc <= in_prod (zero-extended), count <= 1, ovf <= 0.
  - Next state is DONE if in_last=1, else ACCUM.
- ACCUM, on accept:
  - acc <= acc + in_prod, computed as ACC_W+1 bits; the low ACC_W bits are kept.
  - ovf <= ovf | carry-out.
  - count <= count+1, saturating at 2^CNT_W-1.
  - Next state is DONE if in_last=1.
- ACCUM with no accept: all registers hold.
- DONE:
  - out_valid=1; out_sum, out_count and out_overflow are registered and stable while out_valid=1.
  - When out_valid && out_ready at a rising edge: next state IDLE and out_valid falls.
  - A beat offered in that same cycle is NOT accepted (in_ready=0); it is accepted at the earliest on the following cycle.
- Latency: out_valid rises on the first rising edge after the cycle in which the in_last beat is accepted. That beat is included in out_sum.
- clr=1 (with rst=0): next state IDLE; acc, count, ovf and out_valid cleared. clr overrides any simultaneous accept or out handshake. rst overrides clr.
- Reset or clr asserted mid-group discards the partial sum. No result is produced for that group.
- A single-beat group (in_last on the first beat) is legal and yields count=1.
- in_prod=0 beats are counted normally.
- out_sum, out_count and out_overflow hold their last values outside DONE. Only out_valid qualifies them.

Test Plan:
- Reset then group 0,5,25,80,80,9945 (last on 9945), out_ready=1 -> one cycle after the last accept: out_valid=1, out_sum=10135 (0x002797), out_count=6, out_overflow=0; next cycle out_valid=0, in_ready=1.
- Single beat 65025 with in_last=1 -> out_sum=65025, out_count=1, out_overflow=0.
- 259 beats of 65025 (last on beat 259) -> out_sum=64259, out_overflow=1, out_count=255 (saturated). With 258 beats instead -> out_sum=16776450, out_overflow=0, out_count=255.
- Backpressure: group 5,5 (last) with out_ready=0 for 4 cycles -> out_valid stays 1, out_sum=10 stable, in_ready=0, and a pending in_valid beat of 7 is not accepted. Raise out_ready -> handshake completes; beat 7 is accepted the next cycle and starts a new group with acc=7.
- Abort: beats 100,200, then rst=1 for one cycle, then 3 with last -> out_sum=3, out_count=1, and no result is ever presented for 300. Repeat using clr=1 asserted in the same cycle as a valid beat -> the beat is dropped and state=IDLE.
- clr asserted while out_valid=1 and out_ready=1 -> out_valid=0 next cycle, registers cleared, and no double handshake occurs.
